// File: rtl/rate_pkg.sv
// Shared rate-select encodings, detector state encoding and class-to-half-period mapping.
package rate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } rate_state_e;

  typedef enum logic [1:0] {
    SEL_DIV1 = 2'b00,
    SEL_DIV2 = 2'b01,
    SEL_DIV4 = 2'b10,
    SEL_DIV8 = 2'b11
  } rate_sel_e;

  localparam int unsigned NUM_CLASSES = 4;

  function automatic int unsigned nominal_half(input int unsigned base, input rate_sel_e sel);
    return base >> sel;
  endfunction

  function automatic int unsigned half_tol(input int unsigned base, input rate_sel_e sel,
                                           input int unsigned tol_shift);
    return nominal_half(base, sel) >> tol_shift;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Input conditioning for rate_detector: optional 2-flop synchronizer (RATE_DETECTOR_SYNC_EN)
// followed by a previous-value register; flags any level change as an edge.
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic sig_edge
);

  logic level;
  logic prev;

`ifdef RATE_DETECTOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], sig_in};
  end

  assign level = sync_q[1];
`else
  assign level = sig_in;
`endif

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign sig_edge = level ^ prev;

endmodule

// File: rtl/rate_detector.sv
// Measures the half-period of sig_in and locks onto one of four rate classes after CONFIRM
// consecutive matching intervals. Optional input synchronizer: RATE_DETECTOR_SYNC_EN.
module rate_detector
  import rate_pkg::*;
#(
  parameter int unsigned BASE_HALF = 50000000,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned CONFIRM   = 2,
  parameter int unsigned CNT_W     = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sig_in,
  output logic [1:0] select,
  output logic       valid,
  output logic       match_pulse,
  output logic       lost
);

  localparam logic [CNT_W-1:0] TIMEOUT =
    CNT_W'(nominal_half(BASE_HALF, SEL_DIV1) + half_tol(BASE_HALF, SEL_DIV1, TOL_SHIFT));
  localparam logic [1:0] CONFIRM_HITS = 2'(CONFIRM);

  logic             sig_edge;
  logic [CNT_W-1:0] cnt;
  rate_state_e      state, state_d;
  logic [1:0]       hits, hits_d;
  rate_sel_e        cls, cls_d;
  rate_sel_e        sel_q, sel_d;
  logic             match_d, lost_d;
  logic             hit;
  rate_sel_e        hit_cls;
  logic             timeout;

  edge_sync u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .sig_in   (sig_in),
    .sig_edge (sig_edge)
  );

  // Inclusive windows; classes cannot overlap for TOL_SHIFT >= 2, so at most one hits.
  always_comb begin
    hit     = 1'b0;
    hit_cls = SEL_DIV1;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (cnt >= CNT_W'(nominal_half(BASE_HALF, rate_sel_e'(k[1:0]))
                        - half_tol(BASE_HALF, rate_sel_e'(k[1:0]), TOL_SHIFT)) &&
          cnt <= CNT_W'(nominal_half(BASE_HALF, rate_sel_e'(k[1:0]))
                        + half_tol(BASE_HALF, rate_sel_e'(k[1:0]), TOL_SHIFT))) begin
        hit     = 1'b1;
        hit_cls = rate_sel_e'(k[1:0]);
      end
    end
  end

  assign timeout = (cnt == TIMEOUT);

  always_comb begin
    state_d = state;
    hits_d  = hits;
    cls_d   = cls;
    sel_d   = sel_q;
    match_d = 1'b0;
    lost_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sig_edge) begin
          state_d = ST_ARMED;
          hits_d  = '0;
        end
      end
      ST_ARMED: begin
        if (sig_edge) begin
          if (!hit) begin
            hits_d = '0;
          end else begin
            hits_d = (hit_cls == cls) ? hits + 2'd1 : 2'd1;
            cls_d  = hit_cls;
            if (hits_d >= CONFIRM_HITS) begin
              state_d = ST_LOCKED;
              sel_d   = hit_cls;
            end
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          hits_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (sig_edge) begin
          if (hit && hit_cls == sel_q) begin
            match_d = 1'b1;
          end else begin
            state_d = ST_ARMED;
            lost_d  = 1'b1;
            hits_d  = hit ? 2'd1 : 2'd0;
            cls_d   = hit_cls;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          lost_d  = 1'b1;
          hits_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hits        <= '0;
      cls         <= SEL_DIV1;
      sel_q       <= SEL_DIV1;
      valid       <= 1'b0;
      match_pulse <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_d;
      hits        <= hits_d;
      cls         <= cls_d;
      sel_q       <= sel_d;
      valid       <= (state_d == ST_LOCKED);
      match_pulse <= match_d;
      lost        <= lost_d;
      if (state_d == ST_IDLE) cnt <= '0;
      else if (sig_edge)      cnt <= CNT_W'(1);
      else                    cnt <= cnt + 1'b1;
    end
  end

  assign select = sel_q;

endmodule

// File: tb/tb_rate_detector.sv
// Scoreboard bench for rate_detector: each driven edge pushes the expected outputs for the
// cycle they should appear; a negedge monitor pops and compares them.
module tb_rate_detector;

  localparam int unsigned BASE_HALF = 64;
  localparam int unsigned TOL_SHIFT = 4;
  localparam int unsigned CONFIRM   = 2;
  localparam int unsigned CNT_W     = 8;
`ifdef RATE_DETECTOR_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct packed {
    int unsigned cyc;
    int unsigned id;
    logic        v;
    logic [1:0]  s;
    logic        m;
    logic        l;
  } exp_t;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       sig_in = 1'b0;
  logic [1:0] select;
  logic       valid;
  logic       match_pulse;
  logic       lost;

  int unsigned cyc     = 0;
  int unsigned exp_id  = 0;
  int          chk_cnt = 0;
  int          err_cnt = 0;
  bit          mon_en  = 1'b0;
  exp_t        exp_q[$];

  rate_detector #(
    .BASE_HALF (BASE_HALF),
    .TOL_SHIFT (TOL_SHIFT),
    .CONFIRM   (CONFIRM),
    .CNT_W     (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .select      (select),
    .valid       (valid),
    .match_pulse (match_pulse),
    .lost        (lost)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned at, input logic v, input logic [1:0] s,
                           input logic m, input logic l);
    exp_t e;
    e.cyc = at;
    e.id  = exp_id;
    e.v   = v;
    e.s   = s;
    e.m   = m;
    e.l   = l;
    exp_id++;
    exp_q.push_back(e);
  endtask

  // Toggle sig_in n cycles after the previous toggle and expect the given outputs LAT later.
  task automatic step(input int unsigned n, input logic v, input logic [1:0] s,
                      input logic m, input logic l);
    repeat (n) @(posedge clock);
    #1 sig_in = ~sig_in;
    expect_at(cyc + LAT, v, s, m, l);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check_val($sformatf("e%0d_cycle", e.id), cyc, e.cyc);
        check_val($sformatf("e%0d_valid", e.id), 32'(valid), 32'(e.v));
        check_val($sformatf("e%0d_select", e.id), 32'(select), 32'(e.s));
        check_val($sformatf("e%0d_match_pulse", e.id), 32'(match_pulse), 32'(e.m));
        check_val($sformatf("e%0d_lost", e.id), 32'(lost), 32'(e.l));
      end else begin
        check_val("quiet_pulses", 32'({match_pulse, lost}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_select", 32'(select), 32'd0);
    check_val("rst_pulses", 32'({match_pulse, lost}), 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;

    // Lock at 32-cycle half-period
    step(5,  1'b0, 2'b00, 1'b0, 1'b0);
    step(32, 1'b0, 2'b00, 1'b0, 1'b0);
    step(32, 1'b1, 2'b01, 1'b0, 1'b0);
    step(32, 1'b1, 2'b01, 1'b1, 1'b0);
    step(32, 1'b1, 2'b01, 1'b1, 1'b0);

    // Class 2 tolerance edges
    step(16, 1'b0, 2'b01, 1'b0, 1'b1);
    step(16, 1'b1, 2'b10, 1'b0, 1'b0);
    step(15, 1'b1, 2'b10, 1'b1, 1'b0);
    step(17, 1'b1, 2'b10, 1'b1, 1'b0);
    step(18, 1'b0, 2'b10, 1'b0, 1'b1);

    // Class 3 zero tolerance
    step(8,  1'b0, 2'b10, 1'b0, 1'b0);
    step(8,  1'b1, 2'b11, 1'b0, 1'b0);
    step(9,  1'b0, 2'b11, 1'b0, 1'b1);
    step(8,  1'b0, 2'b11, 1'b0, 1'b0);
    step(8,  1'b1, 2'b11, 1'b0, 1'b0);
    step(8,  1'b1, 2'b11, 1'b1, 1'b0);

    // Timeout: no edge once the counter reaches 68
    expect_at(cyc + LAT + 68, 1'b0, 2'b11, 1'b0, 1'b1);
    repeat (LAT + 75) @(posedge clock);

    // Class 0 with an edge exactly at the timeout threshold, then the lower bound
    step(3,  1'b0, 2'b11, 1'b0, 1'b0);
    step(64, 1'b0, 2'b11, 1'b0, 1'b0);
    step(64, 1'b1, 2'b00, 1'b0, 1'b0);
    step(68, 1'b1, 2'b00, 1'b1, 1'b0);
    step(60, 1'b1, 2'b00, 1'b1, 1'b0);

    // Rate changes 64 -> 32 -> 16
    step(32, 1'b0, 2'b00, 1'b0, 1'b1);
    step(32, 1'b1, 2'b01, 1'b0, 1'b0);
    step(16, 1'b0, 2'b01, 1'b0, 1'b1);
    step(16, 1'b1, 2'b10, 1'b0, 1'b0);

    // Reset while locked
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    sig_in = 1'b0;
    @(posedge clock);
    #1;
    check_val("midrst_valid", 32'(valid), 32'd0);
    check_val("midrst_select", 32'(select), 32'd0);
    check_val("midrst_pulses", 32'({match_pulse, lost}), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    step(5,  1'b0, 2'b00, 1'b0, 1'b0);
    step(16, 1'b0, 2'b00, 1'b0, 1'b0);
    step(16, 1'b1, 2'b10, 1'b0, 1'b0);
    step(16, 1'b1, 2'b10, 1'b1, 1'b0);

    repeat (LAT + 3) @(posedge clock);
    #1;
    check_val("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
